// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: two-requester write arbiter/sequencer for an enable-gated flop bank with read-back check.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise requester 0 has fixed priority.
module dff_bank_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             ack0,
  output logic             ack1,
  output logic             bank_en,
  output logic [WIDTH-1:0] bank_d,
  input  logic [WIDTH-1:0] bank_q,
  output logic             owner,
  output logic             busy,
  output logic             err
);
  typedef enum logic [2:0] {IDLE, GRANT, WRITE, CHECK, ACK} state_t;
  state_t r_state, w_next;
  logic r_owner, r_ack0, r_ack1, r_bank_en, r_busy, r_err;
  logic [WIDTH-1:0] r_hold;
  logic w_win, w_start;
  assign w_start = (r_state == IDLE) && (req0 || req1);
`ifdef ARB_ROUND_ROBIN_EN
  logic r_ptr;
  assign w_win = (req0 && req1) ? ~r_ptr : req1;
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= 1'b1;
    else if (w_start) r_ptr <= w_win;
  end
`else
  assign w_win = ~req0 & req1;
`endif
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = (req0 || req1) ? GRANT : IDLE;
      GRANT:   w_next = WRITE;
      WRITE:   w_next = CHECK;
      CHECK:   w_next = ACK;
      default: w_next = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_hold    <= '0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_bank_en <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_bank_en <= w_next == WRITE;
      r_busy    <= w_next != IDLE;
      r_ack0    <= (w_next == ACK) && !r_owner;
      r_ack1    <= (w_next == ACK) && r_owner;
      if (w_start) begin
        r_owner <= w_win;
        r_hold  <= w_win ? d1 : d0;
      end
      if (r_state == CHECK && bank_q != r_hold) r_err <= 1'b1;
    end
  end
  assign ack0    = r_ack0;
  assign ack1    = r_ack1;
  assign bank_en = r_bank_en;
  assign bank_d  = r_hold;
  assign owner   = r_owner;
  assign busy    = r_busy;
  assign err     = r_err;
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb_dff_bank_arbiter: directed checks of arbitration, write timing, read-back error and reset abort.
module tb_dff_bank_arbiter;
  logic       clk = 1'b0;
  logic       rst, req0, req1, fault;
  logic [7:0] d0, d1, bank_d, bank_q, r_mem;
  logic       ack0, ack1, bank_en, owner, busy, err;
  int tests = 0;
  int fails = 0;
  localparam bit RR =
`ifdef ARB_ROUND_ROBIN_EN
    1'b1;
`else
    1'b0;
`endif
  dff_bank_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
    .ack0(ack0), .ack1(ack1), .bank_en(bank_en), .bank_d(bank_d), .bank_q(bank_q),
    .owner(owner), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk) begin
    if (rst) r_mem <= 8'h00;
    else if (bank_en) r_mem <= bank_d;
  end
  assign bank_q = fault ? 8'h00 : r_mem;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask
  // Called just after the edge that sampled the request; leaves the bench one cycle into IDLE.
  task automatic expect_txn(input logic o, input logic [7:0] dat, input logic drop);
    chk("grant_busy", busy, 1);
    chk("grant_owner", owner, o);
    chk("grant_en", bank_en, 0);
    tick;
    chk("write_en", bank_en, 1);
    chk("write_d", bank_d, dat);
    chk("write_ack", ack0 | ack1, 0);
    tick;
    chk("check_en", bank_en, 0);
    chk("check_q", bank_q, fault ? 8'h00 : dat);
    tick;
    chk("ack0", ack0, !o);
    chk("ack1", ack1, o);
    chk("ack_owner", owner, o);
    if (drop) begin
      if (o) req1 = 1'b0;
      else req0 = 1'b0;
    end
    tick;
    chk("idle_ack", ack0 | ack1, 0);
    chk("idle_busy", busy, 0);
    chk("idle_owner", owner, o);
  endtask
  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; d0 = 8'h00; d1 = 8'h00; fault = 1'b0;
    tick;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_ack", {ack1, ack0}, 0);
    chk("rst_en", bank_en, 0);
    chk("rst_d", bank_d, 0);
    chk("rst_owner", owner, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick;
    chk("idle_quiet", busy, 0);
    // Tie with each requester dropping on its ack: 0 first, then 1 five cycles later.
    req0 = 1'b1; req1 = 1'b1; d0 = 8'h11; d1 = 8'h22;
    tick;
    expect_txn(1'b0, 8'h11, 1'b1);
    tick;
    expect_txn(1'b1, 8'h22, 1'b1);
    chk("tie_bank", bank_q, 8'h22);
    // Both held: first tie goes to 0 in both modes, second differs by mode.
    req0 = 1'b1; req1 = 1'b1; d0 = 8'h33; d1 = 8'h44;
    tick;
    expect_txn(1'b0, 8'h33, 1'b0);
    tick;
    expect_txn(RR, RR ? 8'h44 : 8'h33, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    tick;
    chk("idle_noreq", busy, 0);
    req0 = 1'b1; d0 = 8'hA5;
    tick;
    expect_txn(1'b0, 8'hA5, 1'b1);
    chk("single_err", err, 0);
    chk("single_bank", bank_q, 8'hA5);
    // One-cycle pulse on req1 still completes.
    req1 = 1'b1; d1 = 8'h5A;
    tick;
    req1 = 1'b0;
    expect_txn(1'b1, 8'h5A, 1'b0);
    chk("drop_bank", bank_q, 8'h5A);
    fault = 1'b1; req0 = 1'b1; d0 = 8'hFF;
    tick;
    chk("fault_err_pre", err, 0);
    expect_txn(1'b0, 8'hFF, 1'b1);
    chk("fault_err", err, 1);
    fault = 1'b0;
    req0 = 1'b1; d0 = 8'h3C;
    tick;
    expect_txn(1'b0, 8'h3C, 1'b1);
    chk("err_sticky", err, 1);
    chk("good_bank", bank_q, 8'h3C);
    // Reset during WRITE aborts with no ack.
    req0 = 1'b1; d0 = 8'h77;
    tick;
    req0 = 1'b0;
    tick;
    chk("abort_write_en", bank_en, 1);
    rst = 1'b1;
    tick;
    chk("abort_en", bank_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ack", {ack1, ack0}, 0);
    chk("abort_err", err, 0);
    rst = 1'b0;
    tick;
    chk("abort_noack", {ack1, ack0}, 0);
    chk("abort_bank", bank_q, 8'h00);
    req0 = 1'b1; d0 = 8'h99;
    tick;
    expect_txn(1'b0, 8'h99, 1'b1);
    chk("post_abort_bank", bank_q, 8'h99);
    // Back-to-back with req0 held and data advanced after each ack.
    req0 = 1'b1; d0 = 8'h01;
    tick;
    expect_txn(1'b0, 8'h01, 1'b0);
    d0 = 8'h02;
    tick;
    expect_txn(1'b0, 8'h02, 1'b0);
    d0 = 8'h03;
    tick;
    expect_txn(1'b0, 8'h03, 1'b0);
    req0 = 1'b0;
    chk("b2b_bank", bank_q, 8'h03);
    chk("b2b_err", err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
